// File: rtl/seq_8_ctrl_pkg.sv
// seq_8_ctrl_pkg: shared definitions for the seq_8 sequencer.
// State encodings and the default detector width. The detector and its bench
// use the same values.
package seq_8_ctrl_pkg;

    localparam int SEQ_PAT_W = 8;
    localparam int SEQ_CNT_W = 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_DETECT = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/seq_8_ctrl_if.sv
// seq_8_ctrl_if: pattern/threshold request channel into the sequencer.
// The front end is the master; seq_8_ctrl is the slave and drives cfg_ready.
interface seq_8_ctrl_if
    import seq_8_ctrl_pkg::*;
#(
    parameter int PAT_W = SEQ_PAT_W,
    parameter int CNT_W = SEQ_CNT_W
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [PAT_W-1:0] cfg_pattern;
    logic             cfg_msb_first;
    logic [CNT_W-1:0] cfg_threshold;

    modport master (
        output cfg_valid,
        output cfg_pattern,
        output cfg_msb_first,
        output cfg_threshold,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_pattern,
        input  cfg_msb_first,
        input  cfg_threshold,
        output cfg_ready
    );
endinterface

// File: rtl/seq_8_ctrl_pat_shifter.sv
// seq_pat_shifter: parallel-load pattern shift register feeding the detector.
// Loaded on accept, shifted once per LOAD cycle in the latched direction.
// first_bit is taken straight from the incoming pattern so the first detector
// bit can be registered on the accept edge; next_bit is the bit that follows
// the current head. bits_left is a down-counter; last_bit marks the final LOAD
// cycle.
module seq_pat_shifter
    import seq_8_ctrl_pkg::*;
#(
    parameter int PAT_W = SEQ_PAT_W
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] pattern,
    input  logic             msb_first,
    output logic             first_bit,
    output logic             next_bit,
    output logic             last_bit
);
    localparam int BC_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;

    logic [PAT_W-1:0] sr;
    logic             msb_q;
    logic [BC_W-1:0]  bits_left;

    assign first_bit = msb_first ? pattern[PAT_W-1] : pattern[0];
    assign next_bit  = msb_q ? sr[PAT_W-2] : sr[1];
    assign last_bit  = (bits_left == '0);

    // load pattern and direction on accept, then shift once per LOAD cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            msb_q     <= 1'b0;
            bits_left <= '0;
        end else if (load) begin
            sr        <= pattern;
            msb_q     <= msb_first;
            bits_left <= BC_W'(PAT_W - 1);
        end else if (shift) begin
            sr <= msb_q ? {sr[PAT_W-2:0], 1'b0} : {1'b0, sr[PAT_W-1:1]};
            if (bits_left != '0) begin
                bits_left <= bits_left - 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_8_ctrl.sv
// seq_8_ctrl: sequencer for the serial-loaded seq_8 detector in the CAN path.
// Accepts a pattern over cfg, shifts it into the detector with det_load high,
// then streams bit_in (delayed one clock) and counts detector hits until the
// latched threshold is reached.
// Optional feature: define SEQ_CTRL_TIMEOUT_EN to abort DETECT with an err
// pulse after TIMEOUT_CYC consecutive cycles without a hit.
//
// state  | meaning
// IDLE   | waiting for a cfg accept; cfg_ready high
// LOAD   | PAT_W cycles shifting the pattern into the detector
// SETTLE | one quiet cycle, load and din low
// DETECT | streaming bit_in to the detector, counting hits
// DONE   | one cycle, done pulse
module seq_8_ctrl
    import seq_8_ctrl_pkg::*;
#(
    parameter int PAT_W       = SEQ_PAT_W,
    parameter int CNT_W       = SEQ_CNT_W,
    parameter int TIMEOUT_CYC = 1023
)(
    input  logic             clk,
    input  logic             rst_n,
    seq_8_ctrl_if.slave      cfg,
    input  logic             stop,
    input  logic             bit_in,
    output logic             det_load,
    output logic             det_din,
    input  logic             det_dout,
    output logic             busy,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic             err
);
    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             hit;
    logic             timeout;
    logic [CNT_W-1:0] thr_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             sh_first;
    logic             sh_next;
    logic             sh_last;

    assign cfg.cfg_ready = (state == ST_IDLE);
    assign accept        = cfg.cfg_valid & cfg.cfg_ready;
    // a hit coinciding with stop is dropped
    assign hit           = (state == ST_DETECT) & det_dout & ~stop;
    assign cnt_inc       = (match_cnt == '1) ? match_cnt : match_cnt + 1'b1;

    seq_pat_shifter #(.PAT_W(PAT_W)) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .shift     (state == ST_LOAD),
        .pattern   (cfg.cfg_pattern),
        .msb_first (cfg.cfg_msb_first),
        .first_bit (sh_first),
        .next_bit  (sh_next),
        .last_bit  (sh_last)
    );

`ifdef SEQ_CTRL_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;

    // idle-time down-counter: full outside DETECT and after each hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if ((state != ST_DETECT) || hit) begin
            tmo_cnt <= TMO_W'(TIMEOUT_CYC);
        end else if (tmo_cnt != '0) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end

    // terminal count on a hitless cycle; a hit or stop in that cycle wins
    assign timeout = (state == ST_DETECT) & ~det_dout & ~stop & (tmo_cnt == TMO_W'(1));
`else
    // no idle counter in this build; DETECT never times out
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                if (stop)         state_nxt = ST_IDLE;
                else if (sh_last) state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_nxt = stop ? ST_IDLE : ST_DETECT;
            end
            ST_DETECT: begin
                if (stop)                          state_nxt = ST_IDLE;
                else if (hit && (cnt_inc == thr_q)) state_nxt = ST_DONE;
                else if (timeout)                  state_nxt = ST_IDLE;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // threshold latch and hit counter; a zero threshold behaves as one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            thr_q     <= '0;
            match_cnt <= '0;
        end else if (accept) begin
            thr_q     <= (cfg.cfg_threshold == '0) ? CNT_W'(1) : cfg.cfg_threshold;
            match_cnt <= '0;
        end else if (hit) begin
            match_cnt <= cnt_inc;
        end
    end

    // registered outputs, decoded from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_load <= 1'b0;
            det_din  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            det_load <= (state_nxt == ST_LOAD);
            busy     <= (state_nxt != ST_IDLE);
            done     <= (state_nxt == ST_DONE);
            err      <= timeout;
            case (state_nxt)
                ST_LOAD:   det_din <= (state == ST_IDLE) ? sh_first : sh_next;
                ST_DETECT: det_din <= bit_in;
                default:   det_din <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_8_ctrl.sv
// tb_seq_8_ctrl: directed scenarios plus a randomized run against a
// queue-based reference model of the sequencer. A small seq_8 model
// supplies det_dout for the pattern-stream scenario. With
// SEQ_CTRL_TIMEOUT_EN defined the timeout scenario replaces the err-tied check.
module tb_seq_8_ctrl;
    localparam int TCYC = 16;

    logic       clk;
    logic       rst_n;
    logic       stop;
    logic       bit_in;
    logic       det_load;
    logic       det_din;
    logic       det_dout;
    logic       busy;
    logic [7:0] match_cnt;
    logic       done;
    logic       err;
    logic       use_det;
    logic       drv_dout;
    logic [7:0] dm_pat;
    logic [7:0] dm_win;

    int total = 0;
    int bad   = 0;

    seq_8_ctrl_if #(.PAT_W(8), .CNT_W(8)) cfg_if ();

    seq_8_ctrl #(.PAT_W(8), .CNT_W(8), .TIMEOUT_CYC(TCYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg       (cfg_if),
        .stop      (stop),
        .bit_in    (bit_in),
        .det_load  (det_load),
        .det_din   (det_din),
        .det_dout  (det_dout),
        .busy      (busy),
        .match_cnt (match_cnt),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // seq_8 model: pattern shifted in under load, window compared otherwise
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_pat <= 8'h00;
            dm_win <= 8'h00;
        end else if (det_load) begin
            dm_pat <= {dm_pat[6:0], det_din};
            dm_win <= 8'h00;
        end else begin
            dm_win <= {dm_win[6:0], det_din};
        end
    end

    assign det_dout = use_det ? (!det_load && (dm_win == dm_pat)) : drv_dout;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        cfg_if.cfg_valid     = 1'b0;
        cfg_if.cfg_pattern   = 8'h00;
        cfg_if.cfg_msb_first = 1'b0;
        cfg_if.cfg_threshold = 8'h00;
        stop     = 1'b0;
        bit_in   = 1'b0;
        drv_dout = 1'b0;
        use_det  = 1'b0;
    endtask

    task automatic do_accept(input logic [7:0] pat, input logic msb, input logic [7:0] thr);
        cfg_if.cfg_valid     = 1'b1;
        cfg_if.cfg_pattern   = pat;
        cfg_if.cfg_msb_first = msb;
        cfg_if.cfg_threshold = thr;
        tick();
        cfg_if.cfg_valid = 1'b0;
    endtask

    task automatic go_idle();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        quiet_inputs();
        #12;
        total++;
        if ({cfg_if.cfg_ready, busy, det_load, det_din, done, err} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_flags: got ready/busy/load/din/done/err=%b want 100000",
                     {cfg_if.cfg_ready, busy, det_load, det_din, done, err});
        end
        total++;
        if (match_cnt !== 8'd0) begin
            bad++;
            $display("FAIL reset_cnt: got %0d want 0", match_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_load_order();
        logic [7:0] seq_v;
        for (int m = 0; m < 2; m++) begin
            seq_v = (m == 0) ? 8'b10110100 : 8'b00101101;
            do_accept(8'hB4, (m == 0), 8'd1);
            for (int i = 0; i < 8; i++) begin
                total++;
                if ({det_load, det_din} !== {1'b1, seq_v[7-i]}) begin
                    bad++;
                    $display("FAIL load_bit m=%0d i=%0d: got load/din=%b%b want 1%b",
                             m, i, det_load, det_din, seq_v[7-i]);
                end
                tick();
            end
            total++;
            if ({det_load, det_din, busy} !== 3'b001) begin
                bad++;
                $display("FAIL settle m=%0d: got load/din/busy=%b want 001", m, {det_load, det_din, busy});
            end
            go_idle();
            total++;
            if ({cfg_if.cfg_ready, busy} !== 2'b10) begin
                bad++;
                $display("FAIL stop_settle m=%0d: got ready/busy=%b want 10", m, {cfg_if.cfg_ready, busy});
            end
        end
    endtask

    task automatic test_threshold();
        logic [7:0] pat_v;
        logic [7:0] last_cnt;
        logic       prev_done;
        logic       ready_ok;
        logic       seq_ok;
        int         n_done;
        int         thr_tab[2];
        int         occ_tab[2];
        logic       q[$];
        int         seen[$];
        pat_v      = 8'hB4;
        thr_tab[0] = 3;
        thr_tab[1] = 0;
        occ_tab[0] = 3;
        occ_tab[1] = 1;
        use_det    = 1'b1;
        for (int t = 0; t < 2; t++) begin
            q.delete();
            seen.delete();
            for (int k = 0; k < 9; k++) q.push_back(1'b0);
            for (int o = 0; o < occ_tab[t]; o++) begin
                for (int b = 7; b >= 0; b--) q.push_back(pat_v[b]);
                for (int k = 0; k < 4; k++) q.push_back(1'b0);
            end
            for (int k = 0; k < 16; k++) q.push_back(1'b0);
            bit_in = q.pop_front();
            do_accept(pat_v, 1'b1, 8'(thr_tab[t]));
            total++;
            if (match_cnt !== 8'd0) begin
                bad++;
                $display("FAIL thr_clear t=%0d: got %0d want 0", t, match_cnt);
            end
            last_cnt  = 8'd0;
            prev_done = 1'b0;
            ready_ok  = 1'b0;
            n_done    = 0;
            while (q.size() > 0) begin
                bit_in = q.pop_front();
                tick();
                if (prev_done && (cfg_if.cfg_ready === 1'b1)) ready_ok = 1'b1;
                if (done === 1'b1) n_done++;
                if (match_cnt !== last_cnt) begin
                    seen.push_back(int'(match_cnt));
                    last_cnt = match_cnt;
                end
                prev_done = done;
            end
            seq_ok = (seen.size() == occ_tab[t]);
            for (int i = 0; i < seen.size(); i++) begin
                if (seen[i] != i + 1) seq_ok = 1'b0;
            end
            total++;
            if (n_done != 1) begin
                bad++;
                $display("FAIL thr_done_count t=%0d: got %0d want 1", t, n_done);
            end
            total++;
            if (!seq_ok) begin
                bad++;
                $display("FAIL thr_cnt_seq t=%0d: got %0d steps ending %0d want 1..%0d",
                         t, seen.size(), last_cnt, occ_tab[t]);
            end
            total++;
            if (!ready_ok) begin
                bad++;
                $display("FAIL thr_ready_after_done t=%0d: got 0 want 1", t);
            end
            total++;
            if (match_cnt !== 8'(occ_tab[t])) begin
                bad++;
                $display("FAIL thr_final t=%0d: got %0d want %0d", t, match_cnt, occ_tab[t]);
            end
        end
        use_det = 1'b0;
        bit_in  = 1'b0;
    endtask

    task automatic test_abort();
        int n_done;
        do_accept(8'h5A, 1'b1, 8'd2);
        repeat (3) tick();
        go_idle();
        total++;
        if ({cfg_if.cfg_ready, busy, det_load, det_din, done} !== 5'b10000) begin
            bad++;
            $display("FAIL abort_load: got ready/busy/load/din/done=%b want 10000",
                     {cfg_if.cfg_ready, busy, det_load, det_din, done});
        end
        n_done = 0;
        repeat (12) begin
            tick();
            if (done === 1'b1) n_done++;
        end
        total++;
        if (n_done != 0) begin
            bad++;
            $display("FAIL abort_no_done: got %0d pulses want 0", n_done);
        end
        do_accept(8'h33, 1'b0, 8'd5);
        repeat (9) tick();
        drv_dout = 1'b1;
        tick();
        total++;
        if (match_cnt !== 8'd1) begin
            bad++;
            $display("FAIL abort_pre_cnt: got %0d want 1", match_cnt);
        end
        stop = 1'b1;
        tick();
        stop     = 1'b0;
        drv_dout = 1'b0;
        total++;
        if ({match_cnt, busy, done} !== {8'd1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL abort_hit_dropped: got cnt=%0d busy=%b done=%b want cnt=1 busy=0 done=0",
                     match_cnt, busy, done);
        end
    endtask

    task automatic test_ignore_cfg();
        do_accept(8'h3C, 1'b1, 8'd10);
        repeat (9) tick();
        drv_dout = 1'b1;
        repeat (2) tick();
        drv_dout = 1'b0;
        do_accept(8'hFF, 1'b0, 8'd1);
        tick();
        total++;
        if ({match_cnt, busy, det_load} !== {8'd2, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL ignore_latch: got cnt=%0d busy=%b load=%b want cnt=2 busy=1 load=0",
                     match_cnt, busy, det_load);
        end
        drv_dout = 1'b1;
        tick();
        drv_dout = 1'b0;
        total++;
        if ({match_cnt, busy, done} !== {8'd3, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL ignore_threshold: got cnt=%0d busy=%b done=%b want cnt=3 busy=1 done=0",
                     match_cnt, busy, done);
        end
        go_idle();
    endtask

    task automatic test_reset_mid_load();
        do_accept(8'hA5, 1'b1, 8'd1);
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({cfg_if.cfg_ready, busy, det_load, det_din, done, err, match_cnt} !== {6'b100000, 8'd0}) begin
            bad++;
            $display("FAIL reset_mid_load: got ready/busy/load/din/done/err=%b cnt=%0d want 100000 cnt=0",
                     {cfg_if.cfg_ready, busy, det_load, det_din, done, err}, match_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) tick();
        total++;
        if ({cfg_if.cfg_ready, busy, det_load} !== 3'b100) begin
            bad++;
            $display("FAIL reset_abandon: got ready/busy/load=%b want 100", {cfg_if.cfg_ready, busy, det_load});
        end
    endtask

`ifdef SEQ_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        do_accept(8'h81, 1'b1, 8'd3);
        repeat (9) tick();
        repeat (TCYC - 1) tick();
        total++;
        if ({err, busy} !== 2'b01) begin
            bad++;
            $display("FAIL tmo_early: got err/busy=%b want 01", {err, busy});
        end
        tick();
        total++;
        if ({err, busy, cfg_if.cfg_ready} !== 3'b101) begin
            bad++;
            $display("FAIL tmo_fire: got err/busy/ready=%b want 101", {err, busy, cfg_if.cfg_ready});
        end
        tick();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL tmo_pulse_len: got err=%b want 0", err);
        end
        do_accept(8'h81, 1'b1, 8'd3);
        repeat (9) tick();
        repeat (TCYC - 1) tick();
        drv_dout = 1'b1;
        tick();
        drv_dout = 1'b0;
        total++;
        if ({err, busy, match_cnt} !== {1'b0, 1'b1, 8'd1}) begin
            bad++;
            $display("FAIL tmo_hit_wins: got err=%b busy=%b cnt=%0d want err=0 busy=1 cnt=1",
                     err, busy, match_cnt);
        end
        go_idle();
    endtask
`else
    task automatic test_err_tied();
        int n_err;
        int n_idle;
        n_err  = 0;
        n_idle = 0;
        do_accept(8'h81, 1'b1, 8'd3);
        repeat (9) tick();
        repeat (2000) begin
            tick();
            if (err !== 1'b0) n_err++;
            if (busy !== 1'b1) n_idle++;
        end
        total++;
        if (n_err != 0 || n_idle != 0) begin
            bad++;
            $display("FAIL err_tied: got err cycles=%0d idle cycles=%0d want 0 and 0", n_err, n_idle);
        end
        go_idle();
    endtask
`endif

    task automatic test_random();
        logic [1:0] script[$];
        logic [1:0] cur;
        logic       m_busy;
        logic       m_detect;
        logic       m_done;
        int         m_cnt;
        int         m_thr;
        int         m_idle;
        logic       e_load;
        logic       e_din;
        logic       e_done;
        logic       e_err;
        logic [7:0] pat;
        logic       msb;
        rst_n = 1'b0;
        quiet_inputs();
        #3;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        m_busy = 0; m_detect = 0; m_done = 0;
        m_cnt = 0; m_thr = 1; m_idle = 0;
        for (int c = 0; c < 3000; c++) begin
            pat    = 8'($urandom);
            msb    = 1'($urandom);
            cfg_if.cfg_valid     = ($urandom_range(0, 3) == 0);
            cfg_if.cfg_pattern   = pat;
            cfg_if.cfg_msb_first = msb;
            cfg_if.cfg_threshold = 8'($urandom_range(0, 4));
            stop     = ($urandom_range(0, 39) == 0);
            bit_in   = 1'($urandom);
            drv_dout = ($urandom_range(0, 3) == 0);

            e_done = 1'b0;
            e_err  = 1'b0;
            e_load = 1'b0;
            e_din  = 1'b0;
            if (!m_busy) begin
                if (cfg_if.cfg_valid) begin
                    script.delete();
                    for (int i = 0; i < 8; i++) script.push_back({1'b1, msb ? pat[7-i] : pat[i]});
                    script.push_back(2'b00);
                    m_thr    = (cfg_if.cfg_threshold == 0) ? 1 : int'(cfg_if.cfg_threshold);
                    m_cnt    = 0;
                    m_busy   = 1;
                    m_detect = 0;
                    m_done   = 0;
                    cur      = script.pop_front();
                    e_load   = cur[1];
                    e_din    = cur[0];
                end
            end else if (stop || m_done) begin
                m_busy = 0; m_detect = 0; m_done = 0;
                script.delete();
            end else if (script.size() > 0) begin
                cur    = script.pop_front();
                e_load = cur[1];
                e_din  = cur[0];
            end else if (!m_detect) begin
                m_detect = 1;
                m_idle   = 0;
                e_din    = bit_in;
            end else if (drv_dout) begin
                if (m_cnt < 255) m_cnt++;
                m_idle = 0;
                if (m_cnt == m_thr) begin
                    m_detect = 0;
                    m_done   = 1;
                    e_done   = 1'b1;
                end else begin
                    e_din = bit_in;
                end
            end else begin
                m_idle++;
                e_din = bit_in;
`ifdef SEQ_CTRL_TIMEOUT_EN
                if (m_idle == TCYC) begin
                    m_busy = 0; m_detect = 0;
                    e_err  = 1'b1;
                    e_din  = 1'b0;
                end
`endif
            end

            tick();
            total++;
            if ({det_load, det_din, busy, done, err, cfg_if.cfg_ready} !==
                {e_load, e_din, m_busy, e_done, e_err, ~m_busy}) begin
                bad++;
                $display("FAIL rand_outputs c=%0d: got load/din/busy/done/err/ready=%b want %b", c,
                         {det_load, det_din, busy, done, err, cfg_if.cfg_ready},
                         {e_load, e_din, m_busy, e_done, e_err, ~m_busy});
            end
            total++;
            if (match_cnt !== 8'(m_cnt)) begin
                bad++;
                $display("FAIL rand_cnt c=%0d: got %0d want %0d", c, match_cnt, m_cnt);
            end
        end
        quiet_inputs();
    endtask

    initial begin
        test_reset();
        test_load_order();
        test_threshold();
        test_abort();
        test_ignore_cfg();
        test_reset_mid_load();
`ifdef SEQ_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_err_tied();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
